data_mem_access: RTL and testbench
==================================

// Module: data_mem_access
// PURPOSE
//  Initiator side of the data-memory port: MEM-stage load/store unit of the pipelined CPU.
//  Takes load/store from EX/MEM, steers byte lanes, issues req/ack transaction to the data memory.
//  Stalls the pipeline until ack, returns sign/zero-extended load data.
//  Little-endian: byte at addr A maps to data[7:0], A+3 to data[31:24].
// PARAMETERS
//  TIMEOUT   16  max cycles in BUSY without mem_ack_i before abort (>=1)
//  CNT_W      5  width of timeout counter; must hold TIMEOUT
// PORTS
//  clk_i        in   1   single clock, rising edge
//  rst_n_i      in   1   asynchronous, active-low reset
//  MemRe_i      in   1   load request from pipeline
//  MemWr_i      in   1   store request; wins if both high
//  size_i       in   2   00 byte, 01 half, 10 word; 11 treated as word
//  unsigned_i   in   1   1 = zero-extend load, 0 = sign-extend
//  addr_i       in   32  byte address
//  data_i       in   32  store data, right-justified
//  data_o       out  32  extended load data, valid in DONE
//  stall_o      out  1   hold pipeline (combinational)
//  misalign_o   out  1   one-cycle pulse, misaligned access rejected
//  timeout_o    out  1   one-cycle pulse in DONE, transaction aborted
//  mem_req_o    out  1   request valid to memory
//  mem_we_o     out  1   1 = write
//  mem_addr_o   out  32  word-aligned address {addr_i[31:2],2'b00}
//  mem_be_o     out  4   byte enables
//  mem_wdata_o  out  32  store data replicated to selected lanes
//  mem_ack_i    in   1   memory completed transaction (one-cycle pulse)
//  mem_rdata_i  in   32  read word, valid with mem_ack_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, incl. data_o, mem_be_o, counter; async (mem_req_o drops at once).
//  start = (MemRe_i|MemWr_i) & aligned; aligned: byte any, half addr[0]=0, word addr[1:0]=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: start -> latch we/size/unsigned/lane/addr/wdata/be, go BUSY; stall_o=start.
//         Misaligned request: misalign_o=1 that cycle, no stall, no memory request, stays IDLE.
//   BUSY: mem_req_o=1, address/data/be held stable until ack; stall_o=1; counter increments.
//         mem_ack_i -> capture extended rdata (loads) into data_o, go DONE.
//         Counter reaches TIMEOUT-1 without ack -> data_o=0, timeout flag set, go DONE.
//   DONE: stall_o=0, mem_req_o=0, data_o valid; timeout_o=flag; pipeline advances on this edge;
//         unconditionally -> IDLE. No new request accepted in DONE.
//  Latency: request seen cycle 0, mem_req_o cycle 1; ack in cycle k -> data_o valid cycle k+1.
//  Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
//  Write data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Load extract: byte rdata[8*addr[1:0]+:8], half rdata[16*addr[1]+:16], extend per unsigned_i.
//  Store: data_o unchanged. mem_ack_i outside BUSY is ignored.
//  Ack on the same cycle as the TIMEOUT terminal count: ack wins, no timeout.
//  Reset mid-transaction: abort immediately, return to IDLE; no retry.
//  data_o holds its value outside DONE until the next completed load.
// STRUCTURE
//  Shared package mem_pkg: size encodings SZ_B/SZ_H/SZ_W, FSM state typedef (IDLE/BUSY/DONE).
//  Sub-module lsu_align (combinational): be/wdata generation, aligned check, load extract/extend.
//  Top holds the FSM, latch registers, timeout counter, output registers.
// TESTING
//  Store word 0xDEADBEEF @0x10, ack after 2 cycles -> be=1111, wdata=0xDEADBEEF, stall 3 cycles.
//  Load byte signed @0x13, rdata=0x80FF_0000, ack after 1 cycle -> data_o=0xFFFFFF80 in DONE.
//  Load half unsigned @0x12, rdata=0x8001_1234 -> be=1100, data_o=0x00008001.
//  Load word @0x06 -> misalign_o=1 one cycle, stall_o=0, mem_req_o never asserted.
//  No ack for TIMEOUT=16 cycles -> timeout_o pulse, data_o=0, state IDLE next cycle.
//  rst_n_i low in BUSY -> mem_req_o=0 same cycle; late ack after release ignored, data_o=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   SZ_B / SZ_H / SZ_W : access size encodings on size_i (2'b11 is handled as word)
//   state_e            : transaction FSM states
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit.
// Ports:
//   size_i, lane_i, wdata_i      : incoming access (size, addr[1:0], right-justified store data)
//   aligned_o                    : access is naturally aligned for its size
//   be_o, wdata_o                : byte enables and lane-replicated store data
//   ld_size_i, ld_lane_i,
//   ld_unsigned_i, rdata_i       : latched load attributes and the raw read word
//   rdata_o                      : extracted and sign/zero-extended load data
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic        aligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: enables and replicated data
    always_comb begin
        aligned_o = 1'b1;
        be_o      = 4'b1111;
        wdata_o   = wdata_i;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                aligned_o = ~lane_i[0];
                be_o      = 4'b0011 << lane_i;
                wdata_o   = {2{wdata_i[15:0]}};
            end
            default: begin
                aligned_o = (lane_i == 2'b00);
            end
        endcase
    end

    // Load side: little-endian extract then extend
    always_comb begin
        ld_byte = rdata_i[{ld_lane_i, 3'b000} +: 8];
        ld_half = rdata_i[{ld_lane_i[1], 4'b0000} +: 16];
        case (ld_size_i)
            SZ_B:    rdata_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
            SZ_H:    rdata_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage load/store unit: initiator side of the data-memory req/ack port.
// Accepts a load or store from EX/MEM, stalls the pipeline for the whole memory
// transaction and returns extended load data in the DONE cycle.
// Ports:
//   clk_i, rst_n_i                 : clock, asynchronous active-low reset
//   MemRe_i, MemWr_i               : load / store request (store wins if both)
//   size_i, unsigned_i, addr_i,
//   data_i                         : access size, zero-extend select, byte address, store data
//   data_o                         : load result, valid in DONE, held until the next load
//   stall_o                        : pipeline hold (combinational)
//   misalign_o, timeout_o          : single-cycle error pulses
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_be_o, mem_wdata_o          : memory request, stable throughout BUSY
//   mem_ack_i, mem_rdata_i         : memory completion pulse and read word
module data_mem_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRe_i,
    input  logic        MemWr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [1:0]         lane_q;
    logic [29:0]        waddr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        data_q;
    logic               tout_q;

    logic               req_any;
    logic               aligned;
    logic               start;
    logic               busy;
    logic [3:0]         be;
    logic [31:0]        wdata_rep;
    logic [31:0]        ld_ext;

    lsu_align u_align (
        .size_i        (size_i),
        .lane_i        (addr_i[1:0]),
        .wdata_i       (data_i),
        .aligned_o     (aligned),
        .be_o          (be),
        .wdata_o       (wdata_rep),
        .ld_size_i     (size_q),
        .ld_lane_i     (lane_q),
        .ld_unsigned_i (uns_q),
        .rdata_i       (mem_rdata_i),
        .rdata_o       (ld_ext)
    );

    assign req_any = MemRe_i | MemWr_i;
    assign start   = req_any & aligned;
    assign busy    = (state_q == BUSY);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        we_q    <= MemWr_i;
                        size_q  <= size_i;
                        uns_q   <= unsigned_i;
                        lane_q  <= addr_i[1:0];
                        waddr_q <= addr_i[31:2];
                        wdata_q <= wdata_rep;
                        be_q    <= be;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Ack beats the terminal count when both land together
                    if (mem_ack_i) begin
                        if (!we_q) begin
                            data_q <= ld_ext;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == TERM) begin
                        data_q  <= '0;
                        tout_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    tout_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs are gated so nothing leaks outside BUSY
    assign mem_req_o   = busy;
    assign mem_we_o    = busy & we_q;
    assign mem_addr_o  = busy ? {waddr_q, 2'b00} : '0;
    assign mem_be_o    = busy ? be_q : '0;
    assign mem_wdata_o = busy ? wdata_q : '0;

    assign stall_o    = ((state_q == IDLE) & start) | busy;
    assign misalign_o = (state_q == IDLE) & req_any & ~aligned;
    assign timeout_o  = tout_q;
    assign data_o     = data_q;

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;
    import mem_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        MemRe_i = 1'b0;
    logic        MemWr_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        stall_o;
    logic        misalign_o;
    logic        timeout_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    data_mem_access #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .MemRe_i     (MemRe_i),
        .MemWr_i     (MemWr_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        re;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;     // BUSY cycle index carrying the ack
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;      // expected load result (loads only)
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_data = '0;
    logic [31:0] exp_q[$];
    vec_t        vecs[12];

    function automatic vec_t mk(input logic re, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int dly, input logic mis, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.re = re; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.dly = dly; v.mis = mis;
        v.be = be; v.wd = wd; v.ld = ld;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] e;
        tick();
        MemRe_i = v.re; MemWr_i = v.wr; size_i = v.size; unsigned_i = v.uns;
        addr_i = v.addr; data_i = v.wdata;
        #1;
        check($sformatf("v%0d misalign", idx), {31'b0, misalign_o}, {31'b0, v.mis});
        check($sformatf("v%0d stall_c0", idx), {31'b0, stall_o}, {31'b0, ~v.mis});
        check($sformatf("v%0d req_c0", idx), {31'b0, mem_req_o}, 32'd0);
        check($sformatf("v%0d data_hold", idx), data_o, model_data);
        if (v.mis) begin
            tick();
            MemRe_i = 1'b0; MemWr_i = 1'b0;
            #1;
            check($sformatf("v%0d req_after_mis", idx), {31'b0, mem_req_o}, 32'd0);
            check($sformatf("v%0d mis_pulse_end", idx), {31'b0, misalign_o}, 32'd0);
            return;
        end
        exp_q.push_back(v.wr ? model_data : v.ld);
        if (!v.wr) model_data = v.ld;
        for (int c = 0; c <= v.dly; c++) begin
            tick();
            if (c == v.dly) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = v.rdata;
            end
            #1;
            check($sformatf("v%0d req", idx), {31'b0, mem_req_o}, 32'd1);
            check($sformatf("v%0d stall", idx), {31'b0, stall_o}, 32'd1);
            check($sformatf("v%0d we", idx), {31'b0, mem_we_o}, {31'b0, v.wr});
            check($sformatf("v%0d addr", idx), mem_addr_o, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d be", idx), {28'b0, mem_be_o}, {28'b0, v.be});
            check($sformatf("v%0d wdata", idx), mem_wdata_o, v.wd);
        end
        tick();
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d done_stall", idx), {31'b0, stall_o}, 32'd0);
        check($sformatf("v%0d done_req", idx), {31'b0, mem_req_o}, 32'd0);
        check($sformatf("v%0d done_timeout", idx), {31'b0, timeout_o}, 32'd0);
        check($sformatf("v%0d data_o", idx), data_o, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 1, 0, 4'b1111,
                      32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(1, 0, SZ_B, 0, 32'h13, 32'h0, 32'h80FF_0000, 0, 0, 4'b1000,
                      32'h0, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 0, SZ_H, 1, 32'h12, 32'h0, 32'h8001_1234, 2, 0, 4'b1100,
                      32'h0, 32'h0000_8001);
        vecs[3]  = mk(1, 0, SZ_W, 0, 32'h06, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0);
        vecs[4]  = mk(0, 1, SZ_B, 0, 32'h21, 32'h1234_56A5, 32'h0, 0, 0, 4'b0010,
                      32'hA5A5_A5A5, 32'h0);
        vecs[5]  = mk(1, 0, SZ_H, 0, 32'h20, 32'h0, 32'h0000_F00D, 3, 0, 4'b0011,
                      32'h0, 32'hFFFF_F00D);
        vecs[6]  = mk(0, 1, SZ_H, 0, 32'h02, 32'hCAFE_BABE, 32'h0, 0, 0, 4'b1100,
                      32'hBABE_BABE, 32'h0);
        vecs[7]  = mk(1, 0, SZ_B, 1, 32'h01, 32'h0, 32'h0000_9C00, 1, 0, 4'b0010,
                      32'h0, 32'h0000_009C);
        vecs[8]  = mk(0, 1, SZ_H, 0, 32'h03, 32'h1111_2222, 32'h0, 0, 1, 4'b0000,
                      32'h0, 32'h0);
        vecs[9]  = mk(1, 0, 2'b11, 0, 32'h40, 32'h0, 32'h1234_5678, 0, 0, 4'b1111,
                      32'h0, 32'h1234_5678);
        vecs[10] = mk(0, 1, SZ_W, 0, 32'h102, 32'h5555_AAAA, 32'h0, 0, 1, 4'b0000,
                      32'h0, 32'h0);
        vecs[11] = mk(1, 1, SZ_W, 0, 32'h44, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1, 0, 4'b1111,
                      32'h0BAD_F00D, 32'h0);

        // Reset state
        #2;
        check("rst data_o", data_o, 32'd0);
        check("rst stall", {31'b0, stall_o}, 32'd0);
        check("rst req", {31'b0, mem_req_o}, 32'd0);
        check("rst be", {28'b0, mem_be_o}, 32'd0);
        check("rst timeout", {31'b0, timeout_o}, 32'd0);
        tick();
        rst_n_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Timeout: no ack for TIMEOUT BUSY cycles
        tick();
        MemRe_i = 1'b1; MemWr_i = 1'b0; size_i = SZ_W; unsigned_i = 1'b0;
        addr_i = 32'h80; data_i = '0;
        #1;
        check("to stall_c0", {31'b0, stall_o}, 32'd1);
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            tick();
            check($sformatf("to req c%0d", c), {31'b0, mem_req_o}, 32'd1);
        end
        tick();
        check("to pulse", {31'b0, timeout_o}, 32'd1);
        check("to data_o", data_o, 32'd0);
        check("to done_stall", {31'b0, stall_o}, 32'd0);
        check("to done_req", {31'b0, mem_req_o}, 32'd0);
        model_data = '0;
        tick();
        MemRe_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;   // stray ack in IDLE
        #1;
        check("to pulse_end", {31'b0, timeout_o}, 32'd0);
        check("to idle_req", {31'b0, mem_req_o}, 32'd0);
        check("to idle_stall", {31'b0, stall_o}, 32'd0);
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        #1;
        check("stray ack data_o", data_o, 32'd0);

        // Ack on the terminal-count cycle wins
        tick();
        MemRe_i = 1'b1; size_i = SZ_B; unsigned_i = 1'b0; addr_i = 32'h0;
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            tick();
            if (c == int'(TIMEOUT) - 1) begin
                mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_007F;
            end
            #1;
            check($sformatf("tc req c%0d", c), {31'b0, mem_req_o}, 32'd1);
        end
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        #1;
        check("tc no_timeout", {31'b0, timeout_o}, 32'd0);
        check("tc data_o", data_o, 32'h0000_007F);

        // Reset in BUSY aborts at once; late ack ignored
        tick();
        MemRe_i = 1'b1; size_i = SZ_W; addr_i = 32'h84;
        tick();
        check("rb req_busy", {31'b0, mem_req_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("rb req_drop", {31'b0, mem_req_o}, 32'd0);
        check("rb data_o", data_o, 32'd0);
        tick();
        rst_n_i = 1'b1;
        MemRe_i = 1'b0;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("rb late_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        #1;
        check("rb late_data", data_o, 32'd0);
        check("rb late_timeout", {31'b0, timeout_o}, 32'd0);

        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
